// File: rtl/ir_queue.sv
// ir_queue -- DEPTH-entry prefetch queue of WIDTH-bit instruction words that
// sits between the fetch path and the decoder.
//
// Ports
//   clk     in   1      single clock, all state changes on its rising edge
//   reset   in   1      synchronous active-low reset
//   w       in   1      push request, ir_in is written at the tail when accepted
//   ir_in   in   WIDTH  instruction word to push
//   adv     in   1      pop request, retires the head word (ignored when empty)
//   flush   in   1      discard every stored word and clear ovf
//   ir_out  out  WIDTH  head word, 0 while the queue is empty
//   valid   out  1      at least one word stored
//   full    out  1      count == DEPTH
//   count   out  CW     number of stored words, 0..DEPTH
//   ovf     out  1      sticky flag: a push was dropped because the queue was full
//
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic [WIDTH-1:0] ir_in,
  input  logic             adv,
  input  logic             flush,
  output logic [WIDTH-1:0] ir_out,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  // Storage and control state. The array is never reset: an empty queue
  // masks it on ir_out, so its contents do not matter.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rp;
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_normal;

  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == DEPTH_CNT);

  // A pop frees the head slot at the same edge, so a push into a full queue
  // is still accepted when it coincides with a pop.
  assign w_pop    = adv & w_valid;
  assign w_push   = w & (~w_full | w_pop);
  assign w_drop   = w & w_full & ~w_pop;

  // Flush and reset override both requests; nothing is written or flagged.
  assign w_normal = reset & ~flush;

  // Control state: reset outranks flush, flush outranks normal operation.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Data array: written only by accepted pushes in a normal cycle.
  always_ff @(posedge clk) begin
    if (w_normal && w_push) r_mem[r_wp] <= ir_in;
  end

  assign valid  = w_valid;
  assign full   = w_full;
  assign count  = r_count;
  assign ovf    = r_ovf;
  assign ir_out = w_valid ? r_mem[r_rp] : '0;

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             w;
  logic [WIDTH-1:0] ir_in;
  logic             adv;
  logic             flush;
  logic [WIDTH-1:0] ir_out;
  logic             valid;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf;

  int n_tests;
  int n_fail;

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .w      (w),
    .ir_in  (ir_in),
    .adv    (adv),
    .flush  (flush),
    .ir_out (ir_out),
    .valid  (valid),
    .full   (full),
    .count  (count),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    w = 1'b1; ir_in = d; adv = 1'b0;
    step();
    w = 1'b0;
  endtask

  task automatic pop();
    adv = 1'b1; w = 1'b0;
    step();
    adv = 1'b0;
  endtask

  logic [WIDTH-1:0] seq [4];
  int nxt;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0; w = 1'b0; ir_in = '0; adv = 1'b0; flush = 1'b0;

    // Reset held for three edges
    repeat (3) step();
    reset = 1'b1;
    chk("rst_ir_out", 32'(ir_out), 32'h0);
    chk("rst_valid",  32'(valid),  32'h0);
    chk("rst_full",   32'(full),   32'h0);
    chk("rst_count",  32'(count),  32'h0);
    chk("rst_ovf",    32'(ovf),    32'h0);

    push(16'h0001);
    chk("first_ir_out", 32'(ir_out), 32'h0001);
    chk("first_valid",  32'(valid),  32'h1);
    chk("first_count",  32'(count),  32'h1);
    pop();
    chk("first_drain_count", 32'(count), 32'h0);

    // Fill and order
    push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
    chk("fill_full",   32'(full),   32'h1);
    chk("fill_count",  32'(count),  32'h4);
    chk("fill_head",   32'(ir_out), 32'h0011);
    seq[0] = 16'h0011; seq[1] = 16'h0022; seq[2] = 16'h0033; seq[3] = 16'h0044;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_%0d", i), 32'(ir_out), 32'(seq[i]));
      pop();
    end
    chk("order_empty_out",   32'(ir_out), 32'h0);
    chk("order_empty_valid", 32'(valid),  32'h0);
    chk("order_empty_full",  32'(full),   32'h0);

    // Overflow, then push+pop at full
    push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
    push(16'h0055);
    chk("ovf_count", 32'(count),  32'h4);
    chk("ovf_flag",  32'(ovf),    32'h1);
    chk("ovf_head",  32'(ir_out), 32'h0011);
    w = 1'b1; ir_in = 16'h0066; adv = 1'b1;
    step();
    w = 1'b0; adv = 1'b0;
    chk("fullpp_count", 32'(count),  32'h4);
    chk("fullpp_full",  32'(full),   32'h1);
    chk("fullpp_ovf",   32'(ovf),    32'h1);
    seq[0] = 16'h0022; seq[1] = 16'h0033; seq[2] = 16'h0044; seq[3] = 16'h0066;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_order_%0d", i), 32'(ir_out), 32'(seq[i]));
      pop();
    end
    chk("ovf_drain_count", 32'(count), 32'h0);
    chk("ovf_sticky",      32'(ovf),   32'h1);

    // Wrap: values 1..10, rolling occupancy 1..3
    nxt = 1;
    push(16'd1);
    chk("wrap_cnt1", 32'(count), 32'd1);
    push(16'd2);
    chk("wrap_cnt2", 32'(count), 32'd2);
    push(16'd3);
    chk("wrap_cnt3", 32'(count), 32'd3);
    for (int v = 4; v <= 10; v++) begin
      chk($sformatf("wrap_pp_%0d", v), 32'(ir_out), 32'(nxt));
      w = 1'b1; ir_in = 16'(v); adv = 1'b1;
      step();
      w = 1'b0; adv = 1'b0;
      nxt++;
      chk($sformatf("wrap_pp_cnt_%0d", v), 32'(count), 32'd3);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wrap_tail_%0d", k), 32'(ir_out), 32'(nxt));
      pop();
      nxt++;
      chk($sformatf("wrap_tail_cnt_%0d", k), 32'(count), 32'(2 - k));
    end
    chk("wrap_all_seen", 32'(nxt), 32'd11);
    chk("wrap_empty_out", 32'(ir_out), 32'h0);

    // Flush priority over push and pop
    push(16'h0031); push(16'h0032); push(16'h0033);
    chk("pre_flush_count", 32'(count), 32'h3);
    chk("pre_flush_ovf",   32'(ovf),   32'h1);
    flush = 1'b1; w = 1'b1; ir_in = 16'h00AA; adv = 1'b1;
    step();
    flush = 1'b0; w = 1'b0; adv = 1'b0;
    chk("flush_count", 32'(count),  32'h0);
    chk("flush_ovf",   32'(ovf),    32'h0);
    chk("flush_valid", 32'(valid),  32'h0);
    chk("flush_out",   32'(ir_out), 32'h0);
    push(16'h00BB);
    chk("post_flush_out",   32'(ir_out), 32'h00BB);
    chk("post_flush_count", 32'(count),  32'h1);
    pop();

    // Pops on an empty queue
    pop();
    pop();
    chk("empty_pop_count", 32'(count),  32'h0);
    chk("empty_pop_ovf",   32'(ovf),    32'h0);
    chk("empty_pop_out",   32'(ir_out), 32'h0);
    w = 1'b1; ir_in = 16'h0077; adv = 1'b1;
    step();
    chk("empty_pp_count", 32'(count),  32'h1);
    chk("empty_pp_out",   32'(ir_out), 32'h0077);

    // Single entry: push and pop together replace the head word
    ir_in = 16'h0088;
    step();
    w = 1'b0; adv = 1'b0;
    chk("single_pp_count", 32'(count),  32'h1);
    chk("single_pp_out",   32'(ir_out), 32'h0088);

    // Reset mid-stream drops everything
    push(16'h0099);
    chk("mid_count", 32'(count), 32'h2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_count", 32'(count),  32'h0);
    chk("midrst_valid", 32'(valid),  32'h0);
    chk("midrst_out",   32'(ir_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised successor to the single instruction register: a DEPTH-entry prefetch queue of WIDTH-bit instruction words between the fetch path and the decoder. Fetch pushes words with `w`. The decoder always sees the oldest word on `ir_out` and retires it with `adv`. `flush` discards all prefetched words on a branch or jump, and a sticky overflow flag records pushes that were lost.

## Interface
Parameters:
- WIDTH, 16, instruction word width in bits (≥1)
- DEPTH, 4, queue entries; power of two, ≥2
- CW, $clog2(DEPTH+1), derived width of `count`; not to be overridden

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`
- w  in  1  push request; when accepted, `ir_in` is written at the tail
- ir_in  in  WIDTH  instruction word to push
- adv  in  1  pop request; retires the head word (ignored when empty)
- flush  in  1  discard all entries and clear `ovf`
- ir_out  out  WIDTH  head word; 0 when empty
- valid  out  1  queue holds ≥1 word
- full  out  1  count == DEPTH
- count  out  CW  number of stored words, 0..DEPTH
- ovf  out  1  sticky: a push was dropped

## Operation
- Storage: DEPTH×WIDTH register array; read pointer `rp` and write pointer `wp` of $clog2(DEPTH) bits; both wrap modulo DEPTH naturally.
- Counter: `count` register, CW bits. Status outputs `valid`, `full` and `ir_out` are decoded combinationally from registered state only; no combinational path from any input to any output.
- Per-edge priority, highest first:
  1. reset low: rp=wp=0, count=0, ovf=0. Array contents are don't-care; `ir_out` still reads 0 because the queue is empty.
  2. flush high: rp=wp=0, count=0, ovf=0. `w` and `adv` in the same cycle are ignored; the word on `ir_in` is dropped and does not set `ovf`.
  3. Normal cycle:
     - pop = adv & valid.
     - push = w & (!full | pop). A simultaneous push and pop on a full queue is accepted.
     - push: array[wp]←ir_in, wp←wp+1.
     - pop: rp←rp+1.
     - count ← count + push − pop; unchanged on simultaneous push and pop.
     - w & full & !pop: word dropped, ovf←1. ovf stays 1 until reset or flush.
- `adv` when empty has no effect, is not an error and does not set `ovf`.
- `ir_out` = valid ? array[rp] : 0.
- Single-entry case: a simultaneous push and pop with count==1 leaves count at 1, and `ir_out` shows the newly pushed word after the edge.

## Timing
- Push latency: a word accepted at edge N is on `ir_out` from edge N onward (the cycle after N) if the queue was empty before N. `valid` rises at the same edge.
- Pop latency: `adv` at edge N advances `ir_out` to the next word, or to 0 if the queue becomes empty, immediately after edge N.
- Throughput: one push and one pop per cycle sustained, including at full and at empty+1.
- Flush and reset take effect at the same edge they are sampled. The next cycle shows count=0, valid=0, full=0, ir_out=0, ovf=0.
- Reset mid-stream behaves the same as flush: all in-flight words are lost.
- Pointer wrap: after DEPTH accepted pushes, wp returns to 0; ordering is preserved across the wrap.

## Test plan
- Reset: hold `reset`=0 for 3 edges, then release → ir_out=0, valid=0, full=0, count=0, ovf=0. Push 16'h0001 with w=1 for one cycle → next cycle ir_out=16'h0001, valid=1, count=1.
- Fill and order (DEPTH=4): push 16'h0011, 16'h0022, 16'h0033, 16'h0044 → full=1, count=4. Then pop 4 times → ir_out sequence 0011, 0022, 0033, 0044, then 0, with valid=0 at the end.
- Overflow: at full, push 16'h0055 with adv=0 → count stays 4, ovf=1, 0055 never appears. Next cycle, push 16'h0066 with adv=1 → accepted; after draining, the order is 0022, 0033, 0044, 0066.
- Wrap: run 10 push/pop cycles with a rolling count of 1–3 words, values 1..10 → the pop order is 1..10 exactly and count never goes negative.
- Flush priority: with count=3 and ovf=1, assert flush together with w=1 (ir_in=16'h00AA) and adv=1 → next cycle count=0, ovf=0, valid=0. The next push of 16'h00BB appears on ir_out.
- Empty pop: with count=0, drive adv=1 for 2 cycles → count=0, ovf=0, ir_out=0. Then a simultaneous push of 16'h0077 and adv=1 on the empty queue → count=1, ir_out=0077 (the pop is ignored because the queue was empty at the edge).
